register_bank: RTL and testbench

- Parametrised bank of DEPTH general-purpose registers, each WIDTH bits wide, sharing one input bus and one 3-bit FunSel operation code.
- Any subset of registers is updated per cycle via an enable mask.
- Two independent combinational read ports.
- Adds per-register zero flags, sticky wrap/overflow flags, and an optional saturating increment/decrement mode.

---
 rtl/register_pkg.sv | 20 ++
 rtl/register_cell.sv | 89 ++++++++
 rtl/register_bank.sv | 70 +++++++
 tb/tb_register_bank.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// register_pkg: shared definitions for the register bank.
//   - FunSel operation codes applied to every enabled register.
//   - calc_sw(): read-select width for a bank of a given depth.
package register_pkg;

    localparam logic [2:0] FS_DEC       = 3'b000; // Q - 1
    localparam logic [2:0] FS_INC       = 3'b001; // Q + 1
    localparam logic [2:0] FS_LOAD      = 3'b010; // Q <= I
    localparam logic [2:0] FS_CLR       = 3'b011; // Q <= 0
    localparam logic [2:0] FS_LOADLO_Z  = 3'b100; // Q <= zero-extended I[H-1:0]
    localparam logic [2:0] FS_WRLO      = 3'b101; // lower half <= I[H-1:0]
    localparam logic [2:0] FS_WRHI      = 3'b110; // upper half <= I[H-1:0]
    localparam logic [2:0] FS_LOADLO_SX = 3'b111; // Q <= sign-extended I[H-1:0]

    // Select width for DEPTH registers; never narrower than one bit.
    function automatic int unsigned calc_sw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/register_cell.sv
// register_cell: one bank register with its sticky Wrap flag and zero detect.
// Ports:
//   Clock   - rising-edge clock
//   Reset   - synchronous active-high reset (clears Q and Wrap)
//   I       - shared data input bus
//   FunSel  - operation code (see register_pkg)
//   E       - enable; the register holds when low
//   ClrWrap - clears the sticky Wrap flag (a same-cycle wrap event wins)
//   Q       - current register contents
//   Zero    - high when Q == 0
//   Wrap    - sticky wrap/saturation event flag
module register_cell
    import register_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SAT   = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic             E,
    input  logic             ClrWrap,
    output logic [WIDTH-1:0] Q,
    output logic             Zero,
    output logic             Wrap
);

    localparam int unsigned H = WIDTH / 2;
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_evt;

    always_comb begin
        q_d      = q_q;
        wrap_evt = 1'b0;
        if (E) begin
            case (FunSel)
                FS_DEC: begin
                    if (q_q == ALL_ZERO) begin
                        wrap_evt = 1'b1;
                        q_d      = (SAT != 0) ? ALL_ZERO : ALL_ONES;
                    end else begin
                        q_d = q_q - 1'b1;
                    end
                end
                FS_INC: begin
                    if (q_q == ALL_ONES) begin
                        wrap_evt = 1'b1;
                        q_d      = (SAT != 0) ? ALL_ONES : ALL_ZERO;
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end
                FS_LOAD:      q_d = I;
                FS_CLR:       q_d = ALL_ZERO;
                FS_LOADLO_Z:  q_d = {{H{1'b0}}, I[H-1:0]};
                FS_WRLO:      q_d = {q_q[WIDTH-1:H], I[H-1:0]};
                FS_WRHI:      q_d = {I[H-1:0], q_q[H-1:0]};
                FS_LOADLO_SX: q_d = {{H{I[H-1]}}, I[H-1:0]};
                default:      q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_q    <= ALL_ZERO;
            wrap_q <= 1'b0;
        end else begin
            q_q <= q_d;
            // Set has priority over clear.
            if (wrap_evt) begin
                wrap_q <= 1'b1;
            end else if (ClrWrap) begin
                wrap_q <= 1'b0;
            end
        end
    end

    assign Q    = q_q;
    assign Zero = (q_q == ALL_ZERO);
    assign Wrap = wrap_q;

endmodule

// File: rtl/register_bank.sv
// register_bank: DEPTH general-purpose registers of WIDTH bits sharing one input bus
// and one FunSel code, with two combinational read ports.
// Ports:
//   Clock   - rising-edge clock
//   Reset   - synchronous active-high reset
//   I       - shared data input bus
//   FunSel  - operation applied to every enabled register
//   RegSel  - per-register enable mask
//   ClrWrap - per-register sticky Wrap clear mask
//   OutASel - read-port A index; OutA - its contents (0 if out of range)
//   OutBSel - read-port B index; OutB - its contents (0 if out of range)
//   Zero    - bit k high when register k is zero
//   Wrap    - sticky wrap/saturation flag per register
module register_bank
    import register_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SAT   = 0,
    localparam int unsigned SW   = calc_sw(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [DEPTH-1:0] RegSel,
    input  logic [DEPTH-1:0] ClrWrap,
    input  logic [SW-1:0]    OutASel,
    input  logic [SW-1:0]    OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [DEPTH-1:0] Zero,
    output logic [DEPTH-1:0] Wrap
);

    logic [WIDTH-1:0] q_arr [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_cell
        register_cell #(
            .WIDTH (WIDTH),
            .SAT   (SAT)
        ) u_cell (
            .Clock   (Clock),
            .Reset   (Reset),
            .I       (I),
            .FunSel  (FunSel),
            .E       (RegSel[k]),
            .ClrWrap (ClrWrap[k]),
            .Q       (q_arr[k]),
            .Zero    (Zero[k]),
            .Wrap    (Wrap[k])
        );
    end

    // Selects beyond DEPTH (non-power-of-two banks) read as zero.
    always_comb begin
        OutA = '0;
        if (32'(OutASel) < DEPTH) begin
            OutA = q_arr[OutASel];
        end
    end

    always_comb begin
        OutB = '0;
        if (32'(OutBSel) < DEPTH) begin
            OutB = q_arr[OutBSel];
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: drives a wrapping (SAT=0) and a saturating (SAT=1) register_bank with
// identical stimulus and compares both against an arithmetic reference model.
module tb_register_bank;

    localparam int MAXV = 65535;
    localparam int HB   = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_bus;
    logic [2:0]  fun_sel;
    logic [3:0]  reg_sel;
    logic [3:0]  clr_wrap;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [15:0] out_a [2];
    logic [15:0] out_b [2];
    logic [3:0]  zero  [2];
    logic [3:0]  wrap  [2];

    int m_reg  [2][4];
    bit m_wrap [2][4];
    int pass_cnt  = 0;
    int total_cnt = 0;

    always #10 clk = ~clk;

    register_bank #(.WIDTH(16), .DEPTH(4), .SAT(0)) u_dut_wrap (
        .Clock(clk), .Reset(rst), .I(i_bus), .FunSel(fun_sel), .RegSel(reg_sel),
        .ClrWrap(clr_wrap), .OutASel(a_sel), .OutBSel(b_sel), .OutA(out_a[0]),
        .OutB(out_b[0]), .Zero(zero[0]), .Wrap(wrap[0])
    );

    register_bank #(.WIDTH(16), .DEPTH(4), .SAT(1)) u_dut_sat (
        .Clock(clk), .Reset(rst), .I(i_bus), .FunSel(fun_sel), .RegSel(reg_sel),
        .ClrWrap(clr_wrap), .OutASel(a_sel), .OutBSel(b_sel), .OutA(out_a[1]),
        .OutB(out_b[1]), .Zero(zero[1]), .Wrap(wrap[1])
    );

    // Reference model: instance 0 wraps, instance 1 saturates.
    function automatic void model_step();
        int lo;
        int q;
        bit evt;
        lo = int'(i_bus) % HB;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++) begin
                q   = m_reg[s][k];
                evt = 1'b0;
                if (rst) begin
                    m_reg[s][k]  = 0;
                    m_wrap[s][k] = 1'b0;
                end else begin
                    if (reg_sel[k]) begin
                        case (fun_sel)
                            3'd0: if (q == 0) begin evt = 1'b1; q = (s == 1) ? 0 : MAXV; end
                                  else q = q - 1;
                            3'd1: if (q == MAXV) begin evt = 1'b1; q = (s == 1) ? MAXV : 0; end
                                  else q = q + 1;
                            3'd2: q = int'(i_bus);
                            3'd3: q = 0;
                            3'd4: q = lo;
                            3'd5: q = (q / HB) * HB + lo;
                            3'd6: q = lo * HB + q % HB;
                            3'd7: q = (lo >= HB / 2) ? lo + MAXV + 1 - HB : lo;
                            default: ;
                        endcase
                    end
                    m_reg[s][k] = q;
                    if (evt) m_wrap[s][k] = 1'b1;
                    else if (clr_wrap[k]) m_wrap[s][k] = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic [3:0] exp_zero(input int s);
        logic [3:0] z;
        for (int k = 0; k < 4; k++) z[k] = (m_reg[s][k] == 0);
        return z;
    endfunction

    function automatic logic [3:0] exp_wrap(input int s);
        logic [3:0] w;
        for (int k = 0; k < 4; k++) w[k] = m_wrap[s][k];
        return w;
    endfunction

    task automatic drive(input logic r, input logic [15:0] iv, input logic [2:0] fs,
                         input logic [3:0] rs, input logic [3:0] cw);
        rst = r; i_bus = iv; fun_sel = fs; reg_sel = rs; clr_wrap = cw;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h0, 3'd2, 4'h0, 4'h0);
        tick();
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 16'($urandom), 3'd2, 4'($urandom), 4'h0);
            tick();
        end
        drive(1'b1, 16'($urandom), 3'd1, 4'hF, 4'h0);
        tick();
        drive(1'b0, 16'h0, 3'd2, 4'h0, 4'h0);
        for (int s = 0; s < 2; s++) begin
            total_cnt++;
            if (zero[s] !== 4'hF) $display("FAIL reset_zero[%0d]: got %b want 1111", s, zero[s]);
            else pass_cnt++;
            total_cnt++;
            if (wrap[s] !== 4'h0) $display("FAIL reset_wrap[%0d]: got %b want 0000", s, wrap[s]);
            else pass_cnt++;
        end
        for (int k = 0; k < 4; k++) begin
            a_sel = 2'(k); b_sel = 2'(k);
            #1;
            for (int s = 0; s < 2; s++) begin
                total_cnt++;
                if (out_a[s] !== 16'h0 || out_b[s] !== 16'h0)
                    $display("FAIL reset_out[%0d] r%0d: got %h/%h want 0/0", s, k, out_a[s],
                             out_b[s]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_masked_load();
        drive(1'b0, 16'hBEEF, 3'd2, 4'b0101, 4'h0);
        tick();
        a_sel = 2'd2; b_sel = 2'd1;
        #1;
        for (int s = 0; s < 2; s++) begin
            total_cnt++;
            if (out_a[s] !== 16'hBEEF || out_b[s] !== 16'h0000)
                $display("FAIL masked_load_out[%0d]: got %h/%h want beef/0000", s, out_a[s],
                         out_b[s]);
            else pass_cnt++;
            total_cnt++;
            if (zero[s] !== 4'b1010)
                $display("FAIL masked_load_zero[%0d]: got %b want 1010", s, zero[s]);
            else pass_cnt++;
        end
    endtask

    task automatic test_half_ops();
        logic [2:0]  fs_t  [5] = '{3'd5, 3'd6, 3'd7, 3'd4, 3'd7};
        logic [15:0] in_t  [5] = '{16'h00AB, 16'h00CD, 16'h0080, 16'h0080, 16'h537F};
        logic [15:0] exp_t [5] = '{16'h12AB, 16'hCDAB, 16'hFF80, 16'h0080, 16'h007F};
        drive(1'b0, 16'h1234, 3'd2, 4'b0010, 4'h0);
        tick();
        a_sel = 2'd1;
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, in_t[n], fs_t[n], 4'b0010, 4'h0);
            tick();
            for (int s = 0; s < 2; s++) begin
                total_cnt++;
                if (out_a[s] !== exp_t[n] || out_a[s] !== 16'(m_reg[s][1]))
                    $display("FAIL half_op%0d[%0d]: got %h want %h", n, s, out_a[s], exp_t[n]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 16'hFFFF, 3'd2, 4'b1000, 4'h0);
        tick();
        a_sel = 2'd3;
        drive(1'b0, 16'h0, 3'd1, 4'b1000, 4'h0);
        tick();
        total_cnt++;
        if (out_a[0] !== 16'h0000 || wrap[0] !== 4'b1000 || zero[0][3] !== 1'b1)
            $display("FAIL wrap_inc: got q=%h w=%b z=%b want q=0000 w=1000 z3=1", out_a[0],
                     wrap[0], zero[0]);
        else pass_cnt++;
        total_cnt++;
        if (out_a[1] !== 16'hFFFF || wrap[1] !== 4'b1000)
            $display("FAIL sat_inc: got q=%h w=%b want q=ffff w=1000", out_a[1], wrap[1]);
        else pass_cnt++;
        drive(1'b0, 16'h0, 3'd0, 4'b1000, 4'b1000);
        tick();
        total_cnt++;
        if (out_a[0] !== 16'hFFFF || wrap[0] !== 4'b1000)
            $display("FAIL wrap_set_wins: got q=%h w=%b want q=ffff w=1000", out_a[0], wrap[0]);
        else pass_cnt++;
        total_cnt++;
        if (out_a[1] !== 16'hFFFE || wrap[1] !== 4'b0000)
            $display("FAIL sat_dec_clr: got q=%h w=%b want q=fffe w=0000", out_a[1], wrap[1]);
        else pass_cnt++;
        drive(1'b0, 16'h0, 3'd0, 4'b0000, 4'b1000);
        tick();
        total_cnt++;
        if (wrap[0] !== 4'b0000 || out_a[0] !== 16'hFFFF)
            $display("FAIL wrap_clear: got q=%h w=%b want q=ffff w=0000", out_a[0], wrap[0]);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        a_sel = 2'd0;
        drive(1'b0, 16'h0, 3'd3, 4'b0001, 4'h0);
        tick();
        drive(1'b0, 16'h0, 3'd0, 4'b0001, 4'h0);
        tick();
        total_cnt++;
        if (out_a[1] !== 16'h0000 || wrap[1][0] !== 1'b1)
            $display("FAIL sat_dec: got q=%h w0=%b want q=0000 w0=1", out_a[1], wrap[1][0]);
        else pass_cnt++;
        total_cnt++;
        if (out_a[0] !== 16'hFFFF || wrap[0][0] !== 1'b1)
            $display("FAIL wrap_dec: got q=%h w0=%b want q=ffff w0=1", out_a[0], wrap[0][0]);
        else pass_cnt++;
        drive(1'b0, 16'hFFFF, 3'd2, 4'b0001, 4'h0);
        tick();
        drive(1'b0, 16'h0, 3'd1, 4'b0001, 4'h0);
        tick();
        total_cnt++;
        if (out_a[1] !== 16'hFFFF || out_a[0] !== 16'h0000)
            $display("FAIL sat_inc_hold: got sat=%h wrap=%h want ffff/0000", out_a[1], out_a[0]);
        else pass_cnt++;
    endtask

    task automatic test_read_before_write();
        drive(1'b0, 16'h0005, 3'd2, 4'b0001, 4'h0);
        tick();
        a_sel = 2'd0;
        drive(1'b0, 16'h0, 3'd1, 4'b0001, 4'h0);
        #1;
        for (int s = 0; s < 2; s++) begin
            total_cnt++;
            if (out_a[s] !== 16'h0005)
                $display("FAIL rbw_before[%0d]: got %h want 0005", s, out_a[s]);
            else pass_cnt++;
        end
        tick();
        for (int s = 0; s < 2; s++) begin
            total_cnt++;
            if (out_a[s] !== 16'h0006)
                $display("FAIL rbw_after[%0d]: got %h want 0006", s, out_a[s]);
            else pass_cnt++;
        end
        drive(1'b1, 16'h1234, 3'd2, 4'hF, 4'h0);
        tick();
        drive(1'b0, 16'h0, 3'd2, 4'h0, 4'h0);
        for (int s = 0; s < 2; s++) begin
            total_cnt++;
            if (zero[s] !== 4'hF || wrap[s] !== 4'h0)
                $display("FAIL reset_over_load[%0d]: got z=%b w=%b want 1111/0000", s, zero[s],
                         wrap[s]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [15:0] pick [4];
        for (int n = 0; n < 300; n++) begin
            pick = '{16'hFFFF, 16'h0000, 16'hFFFE, 16'($urandom)};
            drive(($urandom_range(0, 49) == 0), pick[$urandom_range(0, 3)],
                  3'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            tick();
            for (int k = 0; k < 4; k++) begin
                a_sel = 2'(k); b_sel = 2'(3 - k);
                #1;
                for (int s = 0; s < 2; s++) begin
                    total_cnt++;
                    if (out_a[s] !== 16'(m_reg[s][k]) || out_b[s] !== 16'(m_reg[s][3 - k]))
                        $display("FAIL rand_read[%0d] cyc%0d r%0d: got %h/%h want %h/%h", s, n,
                                 k, out_a[s], out_b[s], 16'(m_reg[s][k]),
                                 16'(m_reg[s][3 - k]));
                    else pass_cnt++;
                end
            end
            for (int s = 0; s < 2; s++) begin
                total_cnt++;
                if (zero[s] !== exp_zero(s) || wrap[s] !== exp_wrap(s))
                    $display("FAIL rand_flags[%0d] cyc%0d: got z=%b w=%b want z=%b w=%b", s, n,
                             zero[s], wrap[s], exp_zero(s), exp_wrap(s));
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        drive(1'b1, 16'h0, 3'd2, 4'h0, 4'h0);
        a_sel = 2'd0;
        b_sel = 2'd0;
        test_reset();
        test_masked_load();
        test_half_ops();
        test_wrap();
        test_saturation();
        test_read_before_write();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
